// File: rtl/motor_pwm_decode.sv
// motor_pwm_decode: recovers the signed speed command and brake/coast/fault/sat
// status of one motor from its fwd/rev PWM lines over fixed 1024-cycle windows.
module motor_pwm_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        fwd,
    input  logic        rev,
    input  logic        clr,
    output logic [10:0] speed,
    output logic        vld,
    output logic        brake,
    output logic        coast,
    output logic        fault,
    output logic        sat
);
    logic [9:0]  win_q;
    logic [10:0] fcnt_q, rcnt_q, f_s, r_s, speed_q, speed_d;
    logic [9:0]  f_m, r_m;
    logic        vld_q, brake_q, coast_q, fault_q, sat_q;
    logic        brake_d, coast_d, fault_d, sat_d, end_w, both_full, none, both;
    always_comb begin
        // Counts include this edge's sample; bit 10 set only at exactly 1024.
        f_s       = (fwd && !fcnt_q[10]) ? fcnt_q + 11'd1 : fcnt_q;
        r_s       = (rev && !rcnt_q[10]) ? rcnt_q + 11'd1 : rcnt_q;
        f_m       = f_s[10] ? 10'h3FF : f_s[9:0];
        r_m       = r_s[10] ? 10'h3FF : r_s[9:0];
        end_w     = win_q == 10'd1023;
        both_full = f_s[10] && r_s[10];
        none      = f_s == 11'd0 && r_s == 11'd0;
        both      = f_s != 11'd0 && r_s != 11'd0;
        brake_d   = both_full;
        coast_d   = none;
        fault_d   = both && !both_full;
        sat_d     = (r_s == 11'd0 && f_s[10]) || (f_s == 11'd0 && r_s[10]);
        speed_d   = both_full        ? 11'h000 :
                    none             ? 11'h7FF :
                    both             ? speed_q :
                    r_s == 11'd0     ? {1'b0, f_m} : {1'b1, ~r_m};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
            speed_q <= '0;
            vld_q   <= 1'b0;
            brake_q <= 1'b1;
            coast_q <= 1'b0;
            fault_q <= 1'b0;
            sat_q   <= 1'b0;
        end else if (clr) begin
            win_q  <= '0;
            fcnt_q <= '0;
            rcnt_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            win_q  <= win_q + 10'd1;
            fcnt_q <= end_w ? 11'd0 : f_s;
            rcnt_q <= end_w ? 11'd0 : r_s;
            vld_q  <= end_w;
            if (end_w) begin
                speed_q <= speed_d;
                brake_q <= brake_d;
                coast_q <= coast_d;
                fault_q <= fault_d;
                sat_q   <= sat_d;
            end
        end
    end
    assign speed = speed_q;
    assign vld   = vld_q;
    assign brake = brake_q;
    assign coast = coast_q;
    assign fault = fault_q;
    assign sat   = sat_q;
endmodule

// File: tb/tb_motor_pwm_decode.sv
// tb_motor_pwm_decode: randomized windows checked against a count-based model
// of the decode rules, plus clr/rst interruption scenarios.
module tb_motor_pwm_decode;
    logic        clk = 1'b0;
    logic        rst, fwd, rev, clr;
    logic [10:0] speed;
    logic        vld, brake, coast, fault, sat;
    int          n_chk = 0, n_err = 0;
    int          m_speed, m_brake, m_coast, m_fault, m_sat;

    motor_pwm_decode dut (
        .clk(clk), .rst(rst), .fwd(fwd), .rev(rev), .clr(clr),
        .speed(speed), .vld(vld), .brake(brake), .coast(coast),
        .fault(fault), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int min1023(input int x);
        return x > 1023 ? 1023 : x;
    endfunction

    // Reference: result depends only on how many cycles each line was high.
    task automatic model(input int f, input int r);
        m_brake = 0; m_coast = 0; m_fault = 0; m_sat = 0;
        if (f == 1024 && r == 1024) begin
            m_brake = 1; m_speed = 0;
        end else if (f == 0 && r == 0) begin
            m_coast = 1; m_speed = 2047;
        end else if (f > 0 && r > 0) begin
            m_fault = 1;
        end else if (r == 0) begin
            m_speed = min1023(f); m_sat = (f == 1024) ? 1 : 0;
        end else begin
            m_speed = 1024 + 1023 - min1023(r); m_sat = (r == 1024) ? 1 : 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".speed"}, int'(speed), m_speed);
        chk({tag, ".brake"}, int'(brake), m_brake);
        chk({tag, ".coast"}, int'(coast), m_coast);
        chk({tag, ".fault"}, int'(fault), m_fault);
        chk({tag, ".sat"},   int'(sat),   m_sat);
    endtask

    // Drive n cycles; nf/nr < 0 selects sparse random bits, else a phased PWM of that duty.
    task automatic drive(input int n, input int nf, input int nr, output int f, output int r, output int early);
        int pf = $urandom_range(0, 1023), pr = $urandom_range(0, 1023);
        f = 0; r = 0; early = 0;
        for (int i = 0; i < n; i++) begin
            fwd = nf < 0 ? ($urandom_range(0, 3) == 0) : (((i + pf) % 1024) < nf);
            rev = nr < 0 ? ($urandom_range(0, 3) == 0) : (((i + pr) % 1024) < nr);
            f += int'(fwd); r += int'(rev);
            @(negedge clk);
            if (i < 1023 && vld) early++;
        end
    endtask

    task automatic window(input string tag, input int nf, input int nr);
        int f, r, early;
        drive(1024, nf, nr, f, r, early);
        chk({tag, ".early_vld"}, early, 0);
        chk({tag, ".vld"}, int'(vld), 1);
        model(f, r);
        check_outputs(tag);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".vld"}, int'(vld), 0);
        m_speed = 0; m_brake = 1; m_coast = 0; m_fault = 0; m_sat = 0;
        check_outputs(tag);
    endtask

    initial begin
        int f, r, early, k;
        rst = 1'b1; clr = 1'b0; fwd = 1'b0; rev = 1'b0;
        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst = 1'b0;
        window("fwd300", 300, 0);
        chk("fwd300.hex", int'(speed), 'h12C);
        window("rev723", 0, 723);
        window("brake", 1024, 1024);
        window("coast", 0, 0);
        window("fwd_full", 1024, 0);
        chk("fwd_full.hex", int'(speed), 'h3FF);
        window("fault", 10, 5);
        chk("fault.hold", int'(speed), 'h3FF);
        window("rev_full", 0, 1024);
        window("fwd_1023", 1023, 0);
        // clr mid-window: partial counts dropped, outputs hold
        drive(500, 1024, 1024, f, r, early);
        chk("clr500.early_vld", early, 0);
        clr = 1'b1; fwd = 1'b1; rev = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("clr500.vld", int'(vld), 0);
        check_outputs("clr500.hold");
        window("after_clr", 200, 0);
        // clr on the window's last edge suppresses the result
        drive(1023, 0, 0, f, r, early);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr1023.vld", int'(vld), 0);
        check_outputs("clr1023.hold");
        window("after_clr1023", 0, 1);
        // rst mid-window
        drive(700, 1024, 1024, f, r, early);
        chk("rst700.early_vld", early, 0);
        rst = 1'b1; clr = 1'b1;
        @(negedge clk);
        reset_vals("rst700");
        rst = 1'b0; clr = 1'b0;
        window("after_rst", 0, 0);
        for (int w = 0; w < 20; w++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: window("rnd_fwd", $urandom_range(0, 1024), 0);
                1: window("rnd_rev", 0, $urandom_range(0, 1024));
                2: window("rnd_brake", 1024, 1024);
                3: window("rnd_coast", 0, 0);
                4: window("rnd_fault", $urandom_range(1, 1023), $urandom_range(1, 1023));
                5: window("rnd_sat", 0, 1024);
                default: window("rnd_bits", -1, -1);
            endcase
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
